// File: rtl/snow64_bfloat16_vector_mul_slt.sv
// snow64_bfloat16_vector_mul_slt
//   Multi-cycle vector BFloat16 unit for OpMul and OpSlt over a full data word.
//   The vector is split into NUM_LANES 16-bit lanes; LANES_PER_CYCLE lanes are
//   evaluated per busy cycle, so a command takes NUM_LANES/LANES_PER_CYCLE + 1
//   cycles from accepted in_start to the out_valid pulse.
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_start            command strobe, taken only while out_can_accept_cmd=1
//   in_oper             FpuOper code (OpSlt=2, OpMul=3; anything else yields zeros)
//   in_a, in_b          operand vectors, lane i at bits [16i+15:16i]
//   out_valid           one-cycle pulse, out_data holds the result
//   out_can_accept_cmd  unit can take a command this cycle
//   out_data            result vector, same lane layout, held until next result
module snow64_bfloat16_vector_mul_slt #(
  parameter int NUM_LANES       = 16,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_start,
  input  logic [3:0]                in_oper,
  input  logic [NUM_LANES*16-1:0]   in_a,
  input  logic [NUM_LANES*16-1:0]   in_b,
  output logic                      out_valid,
  output logic                      out_can_accept_cmd,
  output logic [NUM_LANES*16-1:0]   out_data
);

  localparam int W     = NUM_LANES * 16;
  localparam int IDX_W = $clog2(NUM_LANES + 1);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES_PER_CYCLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LANES - LANES_PER_CYCLE);
  localparam logic [3:0] OP_SLT = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;

  if (LANES_PER_CYCLE <= 0 || (NUM_LANES % LANES_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("LANES_PER_CYCLE must be positive and divide NUM_LANES");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_p0, b_p0, res_p0, res_next;
  logic [3:0]       oper_p0;

  // Exponent saturation and packing for the truncated product.
  function automatic logic [15:0] pack_mul(input logic s, input logic signed [9:0] e,
                                           input logic [6:0] mant);
    if (e >= 10'sd255) return {s, 8'hff, 7'h0};
    else if (e <= 10'sd0) return {s, 15'h0};
    else return {s, e[7:0], mant};
  endfunction

  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [9:0] e;
    logic [15:0]       p;
    logic [6:0]        mant;
    s      = a[15] ^ b[15];
    a_nan  = (a[14:7] == 8'hff) && (a[6:0] != 7'h0);
    b_nan  = (b[14:7] == 8'hff) && (b[6:0] != 7'h0);
    a_inf  = (a[14:7] == 8'hff) && (a[6:0] == 7'h0);
    b_inf  = (b[14:7] == 8'hff) && (b[6:0] == 7'h0);
    a_zero = (a[14:7] == 8'h00);
    b_zero = (b[14:7] == 8'h00);
    e = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]}) - 10'sd127;
    p = {1'b1, a[6:0]} * {1'b1, b[6:0]};
    // Product of two [1,2) significands lies in [1,4); renormalise when >= 2.
    if (p[15]) begin
      mant = p[14:8];
      e    = e + 10'sd1;
    end else begin
      mant = p[13:7];
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 16'h7fc0;
    else if (a_inf || b_inf) return {s, 8'hff, 7'h0};
    else if (a_zero || b_zero) return {s, 15'h0};
    else return pack_mul(s, e, mant);
  endfunction

  function automatic logic [15:0] bf16_slt(input logic [15:0] a, input logic [15:0] b);
    logic        a_nan, b_nan, a_z, b_z, sa, sb, lt;
    logic [14:0] ma, mb;
    a_nan = (a[14:7] == 8'hff) && (a[6:0] != 7'h0);
    b_nan = (b[14:7] == 8'hff) && (b[6:0] != 7'h0);
    // Denormals and both zeros collapse to +0 so that -0 == +0.
    a_z = (a[14:7] == 8'h00);
    b_z = (b[14:7] == 8'h00);
    sa  = a_z ? 1'b0 : a[15];
    sb  = b_z ? 1'b0 : b[15];
    ma  = a_z ? 15'h0 : a[14:0];
    mb  = b_z ? 15'h0 : b[14:0];
    if (sa != sb) lt = sa;
    else if (!sa) lt = (ma < mb);
    else lt = (ma > mb);
    return (!a_nan && !b_nan && lt) ? 16'h3f80 : 16'h0000;
  endfunction

  function automatic logic [15:0] lane_op(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      OP_MUL:  return bf16_mul(a, b);
      OP_SLT:  return bf16_slt(a, b);
      default: return 16'h0000;
    endcase
  endfunction

  // Current group merged into the partial result.
  always_comb begin
    res_next = res_p0;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      res_next[(int'(idx) + j)*16 +: 16] =
        lane_op(oper_p0, a_p0[(int'(idx) + j)*16 +: 16], b_p0[(int'(idx) + j)*16 +: 16]);
    end
  end

  // Control: state, group index, handshake and the visible result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= StIdle;
      idx                <= '0;
      out_valid          <= 1'b0;
      out_can_accept_cmd <= 1'b1;
      out_data           <= '0;
    end else begin
      case (state)
        StIdle: begin
          out_valid <= 1'b0;
          if (in_start) begin
            state              <= StBusy;
            idx                <= '0;
            out_can_accept_cmd <= 1'b0;
          end
        end
        StBusy: begin
          idx <= idx + IDX_STEP;
          if (idx == IDX_LAST) begin
            state              <= StDone;
            out_valid          <= 1'b1;
            out_can_accept_cmd <= 1'b1;
            out_data           <= res_next;
          end
        end
        default: begin
          out_valid <= 1'b0;
          if (in_start) begin
            state              <= StBusy;
            idx                <= '0;
            out_can_accept_cmd <= 1'b0;
          end else begin
            state <= StIdle;
          end
        end
      endcase
    end
  end

  // Datapath: operand latch and partial-result accumulation.
  always_ff @(posedge clk) begin
    if (out_can_accept_cmd && in_start) begin
      a_p0    <= in_a;
      b_p0    <= in_b;
      oper_p0 <= in_oper;
    end
    if (state == StBusy) res_p0 <= res_next;
  end

endmodule

// File: tb/tb_snow64_bfloat16_vector_mul_slt.sv
module tb_snow64_bfloat16_vector_mul_slt;

  localparam int NL  = 16;
  localparam int G   = 4;
  localparam int W   = NL * 16;
  localparam int NL2 = 8;
  localparam int G2  = 1;
  localparam int W2  = NL2 * 16;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SLT = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          in_start = 1'b0;
  logic [3:0]    in_oper = '0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          out_valid, out_can_accept_cmd;
  logic [W-1:0]  out_data;

  logic          in_start2 = 1'b0;
  logic [3:0]    in_oper2 = '0;
  logic [W2-1:0] in_a2 = '0, in_b2 = '0;
  logic          out_valid2, out_can_accept_cmd2;
  logic [W2-1:0] out_data2;

  snow64_bfloat16_vector_mul_slt dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_oper(in_oper), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_can_accept_cmd(out_can_accept_cmd), .out_data(out_data));

  snow64_bfloat16_vector_mul_slt #(.NUM_LANES(8), .LANES_PER_CYCLE(8)) dut2 (
    .clk(clk), .rst(rst), .in_start(in_start2), .in_oper(in_oper2), .in_a(in_a2), .in_b(in_b2),
    .out_valid(out_valid2), .out_can_accept_cmd(out_can_accept_cmd2), .out_data(out_data2));

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    string        name;
  } exp_t;
  exp_t q[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] mul_a[6] = '{16'h3fc0, 16'hbf80, 16'h7f00, 16'h0080, 16'h7fc0, 16'h7f80};
  logic [15:0] mul_b[6] = '{16'h3fc0, 16'h4000, 16'h7f00, 16'h0080, 16'h3f80, 16'h0000};
  logic [15:0] mul_e[6] = '{16'h4010, 16'hc000, 16'h7f80, 16'h0000, 16'h7fc0, 16'h7fc0};
  logic [15:0] slt_a[6] = '{16'h3f80, 16'h4000, 16'h8000, 16'hbf80, 16'hc000, 16'h7fc0};
  logic [15:0] slt_b[6] = '{16'h4000, 16'h3f80, 16'h0000, 16'h3f80, 16'hbf80, 16'h3f80};
  logic [15:0] slt_e[6] = '{16'h3f80, 16'h0000, 16'h0000, 16'h3f80, 16'h3f80, 16'h0000};

  function automatic logic [W-1:0] rep6(input logic [15:0] t[6]);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[16*i +: 16] = t[i % 6];
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitors pop the oldest expectation whenever a DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: dut valid at cycle %0d with nothing pending", cyc);
        end else begin
          e = q.pop_front();
          check({e.name, " latency"}, W'(cyc), W'(e.cyc));
          check({e.name, " data"}, out_data, e.data);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid2 === 1'b1) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid2: dut2 valid at cycle %0d with nothing pending", cyc);
        end else begin
          e = q2.pop_front();
          check({e.name, " latency"}, W'(cyc), W'(e.cyc));
          check({e.name, " data"}, W'(out_data2), W'(e.data[W2-1:0]));
        end
      end
    end
  end

  // Called at a falling edge; holds in_start for one cycle.
  task automatic start1(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input bit acc,
                        input bit push);
    check({name, " can_accept"}, W'(out_can_accept_cmd), W'(acc));
    in_start = 1'b1;
    in_oper  = op;
    in_a     = a;
    in_b     = b;
    if (push) q.push_back('{exp, cyc + G + 1, name});
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic start2(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input bit push);
    check({name, " can_accept"}, W'(out_can_accept_cmd2), W'(1));
    in_start2 = 1'b1;
    in_oper2  = op;
    in_a2     = a[W2-1:0];
    in_b2     = b[W2-1:0];
    if (push) q2.push_back('{exp, cyc + G2 + 1, name});
    @(negedge clk);
    in_start2 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d and %0d results still pending, required 0", q.size(), q2.size());
      q.delete();
      q2.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ma, mb, me, sa, sb, se;
    ma = rep6(mul_a); mb = rep6(mul_b); me = rep6(mul_e);
    sa = rep6(slt_a); sb = rep6(slt_b); se = rep6(slt_e);

    repeat (3) @(negedge clk);
    check("reset valid", W'(out_valid), W'(0));
    check("reset can_accept", W'(out_can_accept_cmd), W'(1));
    check("reset data", out_data, '0);
    check("reset valid2", W'(out_valid2), W'(0));
    check("reset can_accept2", W'(out_can_accept_cmd2), W'(1));
    check("reset data2", W'(out_data2), '0);
    rst = 1'b0;
    @(negedge clk);

    start1("mul_all", OP_MUL, {NL{16'h3f80}}, {NL{16'h4000}}, {NL{16'h4000}}, 1, 1);
    drain();
    start1("mul_lanes", OP_MUL, ma, mb, me, 1, 1);
    drain();
    start1("slt_lanes", OP_SLT, sa, sb, se, 1, 1);
    drain();

    // Starts during busy are ignored; a start in the done cycle is back-to-back.
    start1("hs_first", OP_MUL, {NL{16'h3f80}}, {NL{16'h4000}}, {NL{16'h4000}}, 1, 1);
    @(negedge clk);
    start1("hs_ignored_a", OP_ADD, ma, mb, '0, 0, 0);
    start1("hs_ignored_b", OP_MUL, sa, sb, '0, 0, 0);
    @(negedge clk);
    start1("hs_b2b", OP_SLT, sa, sb, se, 1, 1);
    drain();

    start1("add_zero", OP_ADD, ma, mb, '0, 1, 1);
    drain();

    // Reset during the second busy cycle aborts the command.
    start1("rst_abort", OP_MUL, ma, mb, me, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst can_accept", W'(out_can_accept_cmd), W'(1));
    check("rst valid", W'(out_valid), W'(0));
    repeat (8) @(negedge clk);
    start1("after_rst", OP_MUL, ma, mb, me, 1, 1);
    drain();

    start2("w8_mul", OP_MUL, ma, mb, me, 1);
    drain();
    start2("w8_slt", OP_SLT, sa, sb, se, 1);
    drain();
    start2("w8_rst_abort", OP_MUL, ma, mb, me, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("w8 rst can_accept", W'(out_can_accept_cmd2), W'(1));
    check("w8 rst valid", W'(out_valid2), W'(0));
    repeat (5) @(negedge clk);
    start2("w8_after_rst", OP_SLT, sa, sb, se, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
